pll_lock_reset_seq: RTL and testbench
=====================================

# pll_lock_reset_seq

Reset sequencer that sits directly downstream of the ECP5 PLL wrapper. It consumes the PLL `locked` flag, which is asynchronous to the output clock. It runs in the PLL output clock domain (`clkout0`, 400 MHz) and releases a clean synchronous reset to the fast-domain logic only after lock has been stable for a programmable time. On loss of lock it re-asserts that reset immediately and counts the loss events for debug.

## Interface
- `LOCK_CYCLES`, default 4096: consecutive synchronized-lock cycles required before the hold phase starts; must be ≥ 1.
- `HOLD_CYCLES`, default 16: extra cycles reset is held after lock is qualified; must be ≥ 1.
- `CNT_W`, default 8: width of the lock-loss event counter.

Ports:
- `clk` input 1: PLL output clock (`clkout0`). One clock: the single clock domain.
- `rst` input 1: synchronous, active-high reset in the `clk` domain.
- `locked` input 1: raw PLL `LOCK`, asynchronous to `clk`.
- `rst_out` output 1: synchronous active-high reset for downstream fast-domain logic.
- `ready` output 1: high while the sequencer is in RUN.
- `lock_lost` output 1: sticky flag, set on any loss of lock while in RUN.
- `loss_count` output CNT_W: count of losses of lock while in RUN, saturating.

## Operation
- **Synchronizer:** `locked` passes through 2 flops to form `locked_s`. Both flops reset to 0.
- **State machine:** WAIT_LOCK, QUALIFY, HOLD, RUN. A single down/up counter `cnt` is sized `$clog2(max(LOCK_CYCLES,HOLD_CYCLES)+1)`.
- **WAIT_LOCK:**
  - Outputs: `rst_out`=1, `ready`=0, `cnt`=0.
  - Transition: `locked_s`=1 → QUALIFY, with `cnt` = 1.
- **QUALIFY:**
  - Outputs: `rst_out`=1.
  - `locked_s`=0 → WAIT_LOCK. This is a lock glitch; it is **not** counted.
  - `locked_s`=1 and `cnt`==LOCK_CYCLES → HOLD, with `cnt` = 1.
  - Otherwise `cnt`++.
- **HOLD:**
  - Outputs: `rst_out`=1.
  - `locked_s`=0 → WAIT_LOCK, not counted.
  - `cnt`==HOLD_CYCLES → RUN.
  - Otherwise `cnt`++.
- **RUN:**
  - Outputs: `rst_out`=0, `ready`=1.
  - Transition: `locked_s`=0 → WAIT_LOCK.
  - Same edge: `lock_lost`←1 and `loss_count`←`loss_count`+1, saturating at 2^CNT_W−1 (no wrap).
- **Registered outputs:** `rst_out` and `ready` are registered and decoded from the next state, so they change on the same edge as the state.
- **Clearing debug outputs:** `lock_lost` and `loss_count` clear only on `rst`.
- **`rst` priority:** `rst` has priority over everything. On the next edge the block enters WAIT_LOCK and all outputs return to their reset values, including mid-QUALIFY, mid-HOLD and RUN.

## Timing
- **Reset values:** `rst_out`=1, `ready`=0, `lock_lost`=0, `loss_count`=0, state WAIT_LOCK, `cnt`=0, sync flops 0.
- **Release latency:** take edge E as the first edge that samples `locked`=1, with `locked` held high and `rst` low.
  - `locked_s` is 1 after edge E+1.
  - QUALIFY is entered at edge E+2.
  - HOLD is entered at E+2+LOCK_CYCLES.
  - RUN is entered at E+2+LOCK_CYCLES+HOLD_CYCLES.
  - At that last edge `rst_out` falls and `ready` rises together.
- **Assert latency:** take edge F as the first edge that samples `locked`=0 while in RUN.
  - `rst_out` rises and `ready` falls at edge F+2.
  - `loss_count` and `lock_lost` update at that same edge.
- **Glitch filtering:**
  - A `locked` low pulse shorter than 1 cycle may be missed; this is acceptable.
  - Any pulse seen by `locked_s` during QUALIFY or HOLD restarts qualification from WAIT_LOCK.
- **`rst` mid-sequence:** `rst`=1 sampled at edge R gives reset values after R. If `rst` falls and `locked` is still high, the full release latency applies again, counted from the first edge after `rst` falls.
- **No combinational paths:** none from inputs to outputs.

## Test plan
Bench parameters for all scenarios: LOCK_CYCLES=8, HOLD_CYCLES=4, CNT_W=2.

- **Power-up:** `rst`=1 for 3 cycles, `locked` held high from edge 0, `rst` released before edge 3 → `rst_out`=1 and `ready`=0 through edge 3+2+12−1; both flip at edge 17 (E=3); `loss_count`=0.
- **Glitch in QUALIFY:** drop `locked` low for 1 cycle at QUALIFY cnt=5 → return to WAIT_LOCK, `lock_lost`=0, `loss_count`=0; release occurs 14 edges after `locked` is re-sampled high.
- **Loss in RUN:** after release, drive `locked`=0 at edge F → at F+2, `rst_out`=1, `ready`=0, `lock_lost`=1, `loss_count`=1; relock re-releases after the full latency, `lock_lost` still 1.
- **Saturation:** 5 lock/unlock cycles through RUN → `loss_count` reads 1, 2, 3, 3, 3.
- **Reset in HOLD and in RUN:** assert `rst` for 1 cycle during HOLD → WAIT_LOCK and all outputs at reset values on the next edge. Repeat in RUN with `loss_count`=2 → `loss_count`=0, `lock_lost`=0, `rst_out`=1.
- **Glitch in HOLD:** drop `locked` for 2 cycles during HOLD → back to WAIT_LOCK, no count, `ready` never pulses.

Source files
------------

// File: rtl/pll_lock_reset_seq.sv
// Reset sequencer for the PLL output clock domain: qualifies a synchronized
// lock flag, holds reset for a fixed time, then releases it; counts losses of lock.
module pll_lock_reset_seq #(
    parameter int unsigned LOCK_CYCLES = 4096,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    output logic             rst_out,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count
);

    localparam int unsigned MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        QUALIFY,
        HOLD,
        RUN
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [1:0]    sync_q;
    logic          locked_s;
    logic          loss_evt;

    assign locked_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], locked};
        end
    end

    // Loss of synchronized lock always wins over counter completion.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        loss_evt = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_n = '0;
                if (locked_s) begin
                    state_n = QUALIFY;
                    cnt_n   = CW'(1);
                end
            end
            QUALIFY: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_CYCLES)) begin
                    state_n = HOLD;
                    cnt_n   = CW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CW'(HOLD_CYCLES)) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_n  = WAIT_LOCK;
                    cnt_n    = '0;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rst_out <= (state_n != RUN);
            ready   <= (state_n == RUN);
            if (loss_evt) begin
                lock_lost <= 1'b1;
                if (loss_count != '1) begin
                    loss_count <= loss_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with LOCK_CYCLES=8, HOLD_CYCLES=4, CNT_W=2;
// a release takes 14 edges from the first edge sampling locked high.
module tb_pll_lock_reset_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b1;
    logic       rst_out;
    logic       ready;
    logic       lock_lost;
    logic [1:0] loss_count;

    int errors = 0;
    int checks = 0;

    pll_lock_reset_seq #(
        .LOCK_CYCLES(8),
        .HOLD_CYCLES(4),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .locked(locked),
        .rst_out(rst_out),
        .ready(ready),
        .lock_lost(lock_lost),
        .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n active edges; inputs are changed and outputs sampled 1 time unit later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input int r, input int rd, input int ll, input int lc);
        check({tag, ".rst_out"}, int'(rst_out), r);
        check({tag, ".ready"}, int'(ready), rd);
        check({tag, ".lock_lost"}, int'(lock_lost), ll);
        check({tag, ".loss_count"}, int'(loss_count), lc);
    endtask

    // Called just after edge R, with locked already high: E = R+1, release at R+15.
    task automatic expect_release(input string tag);
        step(14);
        check({tag, ".pre_rst_out"}, int'(rst_out), 1);
        check({tag, ".pre_ready"}, int'(ready), 0);
        step(1);
        check({tag, ".rel_rst_out"}, int'(rst_out), 0);
        check({tag, ".rel_ready"}, int'(ready), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    // From RUN: drop locked at edge F, expect outputs to flip at F+2, then relock.
    task automatic lose_lock(input string tag, input int exp_cnt);
        locked = 1'b0;
        step(2);
        check({tag, ".still_ready"}, int'(ready), 1);
        step(1);
        check_outs({tag, ".lost"}, 1, 0, 1, exp_cnt);
        locked = 1'b1;
    endtask

    initial begin
        // Power-up: rst sampled high at edges 0..2, released before edge 3.
        step(3);
        check_outs("pwr_reset", 1, 0, 0, 0);
        rst = 1'b0;
        expect_release("pwr");
        check("pwr.loss_count", int'(loss_count), 0);

        // Glitch in QUALIFY at cnt=5.
        do_reset();
        step(7);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(14);
        check("gq.pre_ready", int'(ready), 0);
        step(1);
        check_outs("gq.rel", 0, 1, 0, 0);

        // Loss in RUN, then relock with the sticky flag retained.
        lose_lock("loss1", 1);
        expect_release("relock");
        check("relock.lock_lost", int'(lock_lost), 1);
        check("relock.loss_count", int'(loss_count), 1);

        // Saturation of a 2-bit counter.
        do_reset();
        expect_release("sat0");
        lose_lock("sat1", 1);
        expect_release("sat1r");
        lose_lock("sat2", 2);
        expect_release("sat2r");
        lose_lock("sat3", 3);
        expect_release("sat3r");
        lose_lock("sat4", 3);
        expect_release("sat4r");
        lose_lock("sat5", 3);

        // Reset during HOLD (entered 11 edges after the lost edge), debug state clears.
        step(12);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_outs("rst_hold", 1, 0, 0, 0);
        expect_release("rst_hold");

        // Reset during RUN with loss_count=2.
        lose_lock("rr1", 1);
        expect_release("rr1r");
        lose_lock("rr2", 2);
        expect_release("rr2r");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_outs("rst_run", 1, 0, 0, 0);
        expect_release("rst_run");

        // Glitch of 2 cycles during HOLD: no RUN pulse, no count.
        do_reset();
        step(12);
        locked = 1'b0;
        step(2);
        locked = 1'b1;
        begin
            int pulsed = 0;
            for (int i = 0; i < 14; i++) begin
                step(1);
                if (ready) pulsed = 1;
            end
            check("gh.ready_pulse", pulsed, 0);
        end
        step(1);
        check_outs("gh.rel", 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
